i2c_slave_regport: RTL and testbench

I2C slave endpoint that answers the 7-bit address set by `SLAVE_ADDR` and exposes a byte-addressed register space through a synchronous RAM port. It is the responder for the I2C master block, sharing the same board-level `scl`/`sda` pins. The I2C register-pointer convention applies: the first written byte sets the pointer, and subsequent bytes are written or read with pointer auto-increment. No clock stretching; `scl` is input-only.

---
 rtl/i2c_slave_regport.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_slave_regport.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regport.sv
// rtl/i2c_slave_regport.sv - I2C slave exposing a byte-addressed register space over a sync RAM port
module i2c_slave_regport #(
    parameter logic [6:0] SLAVE_ADDR = 7'h48,
    parameter int         ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl,
    inout  wire               sda,
    output logic [ADDR_W-1:0] ram_add,
    output logic [7:0]        ram_din,
    output logic              ram_w,
    input  logic [7:0]        ram_dout,
    output logic              busy,
    output logic [7:0]        rx_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_WAIT_STOP
    } state_t;

    state_t state_q, state_d;

    // [0] first sync stage, [1] synchronized value, [2] previous synchronized value
    logic [2:0]        scl_sync_q, sda_sync_q;
    logic [6:0]        shift_q;
    logic [7:0]        tx_q;
    logic [3:0]        bit_cnt_q;
    logic [ADDR_W-1:0] ptr_q;
    logic              ack_clk_q;
    logic              rw_q;
    logic              ram_w_q;
    logic [7:0]        ram_din_q;
    logic              inc_ptr_q;
    logic              busy_q;
    logic [7:0]        rx_count_q;
    logic              fall_d1_q;
    logic              sda_oe_q, sda_oe_d;

    logic       scl_rise, scl_fall, start_det, stop_det, sda_bit;
    logic [7:0] byte_in;
    logic       addr_match;

    assign sda_bit   = sda_sync_q[1];
    assign scl_rise  =  scl_sync_q[1] & ~scl_sync_q[2];
    assign scl_fall  = ~scl_sync_q[1] &  scl_sync_q[2];
    assign start_det =  scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] &  sda_sync_q[2];
    assign stop_det  =  scl_sync_q[1] & scl_sync_q[2] &  sda_sync_q[1] & ~sda_sync_q[2];

    // Byte as it stands once the current (8th) bit is shifted in
    assign byte_in    = {shift_q, sda_bit};
    // General call (address 0) is never acknowledged
    assign addr_match = (shift_q == SLAVE_ADDR) && (shift_q != 7'd0);

    // Open-drain: only ever pull low
    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign ram_add  = ptr_q;
    assign ram_din  = ram_din_q;
    assign ram_w    = ram_w_q;
    assign busy     = busy_q;
    assign rx_count = rx_count_q;

    // Two-stage synchronizers plus one history stage for edge detection; idle bus reads high
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], scl};
            sda_sync_q <= {sda_sync_q[1:0], sda};
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; bus conditions outrank any bit sample in the same clk
    always_comb begin
        state_d = state_q;
        if (start_det) begin
            state_d = S_ADDR;
        end else if (stop_det) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR:      if (scl_rise && bit_cnt_q == 4'd7)
                                 state_d = addr_match ? S_ADDR_ACK : S_WAIT_STOP;
                S_ADDR_ACK:  if (scl_fall && ack_clk_q) state_d = rw_q ? S_RDATA : S_PTR;
                S_PTR:       if (scl_rise && bit_cnt_q == 4'd7) state_d = S_PTR_ACK;
                S_PTR_ACK:   if (scl_fall && ack_clk_q) state_d = S_WDATA;
                S_WDATA:     if (scl_rise && bit_cnt_q == 4'd7) state_d = S_WDATA_ACK;
                S_WDATA_ACK: if (scl_fall && ack_clk_q) state_d = S_WDATA;
                S_RDATA:     if (scl_fall && bit_cnt_q == 4'd8) state_d = S_RDATA_ACK;
                S_RDATA_ACK: begin
                    if (scl_rise && sda_bit)
                        state_d = S_WAIT_STOP;
                    else if (scl_fall && ack_clk_q)
                        state_d = S_RDATA;
                end
                default:     state_d = state_q;
            endcase
        end
    end

    // FSM output: what the slave wants on sda during the current low phase of scl
    always_comb begin
        sda_oe_d = 1'b0;
        case (state_q)
            S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: sda_oe_d = 1'b1;
            S_RDATA:                            sda_oe_d = ~tx_q[7];
            default:                            sda_oe_d = 1'b0;
        endcase
    end

    // Datapath: shifting, pointer, RAM strobes, counters and the registered sda drive
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            tx_q       <= '0;
            bit_cnt_q  <= '0;
            ptr_q      <= '0;
            ack_clk_q  <= 1'b0;
            rw_q       <= 1'b0;
            ram_w_q    <= 1'b0;
            ram_din_q  <= '0;
            inc_ptr_q  <= 1'b0;
            busy_q     <= 1'b0;
            rx_count_q <= '0;
            fall_d1_q  <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            fall_d1_q <= scl_fall;
            ram_w_q   <= 1'b0;
            inc_ptr_q <= 1'b0;
            // Write pointer advances the clk after the strobe so ram_add is stable during it
            if (inc_ptr_q) ptr_q <= ptr_q + 1'b1;

            // Drive changes one clk after the falling-edge detect; bus conditions release it at once
            if (start_det || stop_det) sda_oe_q <= 1'b0;
            else if (fall_d1_q)        sda_oe_q <= sda_oe_d;

            if (start_det) begin
                bit_cnt_q  <= '0;
                ack_clk_q  <= 1'b0;
                rx_count_q <= '0;
            end else if (stop_det) begin
                bit_cnt_q <= '0;
                ack_clk_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR: if (scl_rise) begin
                        shift_q   <= byte_in[6:0];
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q <= '0;
                            rw_q      <= sda_bit;
                            busy_q    <= addr_match;
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_rise) ack_clk_q <= 1'b1;
                        if (scl_fall && ack_clk_q) begin
                            ack_clk_q <= 1'b0;
                            bit_cnt_q <= '0;
                            // Pointer has been stable for many clks, so ram_dout is valid here
                            if (state_q == S_ADDR_ACK && rw_q) tx_q <= ram_dout;
                        end
                    end
                    S_PTR: if (scl_rise) begin
                        shift_q   <= byte_in[6:0];
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q <= '0;
                            ptr_q     <= ADDR_W'(byte_in);
                        end
                    end
                    S_WDATA: if (scl_rise) begin
                        shift_q   <= byte_in[6:0];
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q <= '0;
                            ram_w_q   <= 1'b1;
                            ram_din_q <= byte_in;
                            inc_ptr_q <= 1'b1;
                            if (rx_count_q != 8'hFF) rx_count_q <= rx_count_q + 8'd1;
                        end
                    end
                    S_RDATA: begin
                        if (scl_rise) bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd8) bit_cnt_q <= '0;
                            else                   tx_q <= {tx_q[6:0], 1'b0};
                        end
                    end
                    S_RDATA_ACK: begin
                        if (scl_rise && !sda_bit) begin
                            ack_clk_q <= 1'b1;
                            ptr_q     <= ptr_q + 1'b1;
                        end
                        // Pointer moved at the rise; RAM has long since caught up by the fall
                        if (scl_fall && ack_clk_q) begin
                            ack_clk_q <= 1'b0;
                            bit_cnt_q <= '0;
                            tx_q      <= ram_dout;
                        end
                    end
                    default: begin
                        bit_cnt_q <= bit_cnt_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regport.sv
// tb/tb_i2c_slave_regport.sv - self-checking bench for i2c_slave_regport
`timescale 1ns/1ps
module tb_i2c_slave_regport;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda;
    logic [7:0] ram_add;
    logic [7:0] ram_din;
    logic       ram_w;
    logic [7:0] ram_dout;
    logic       busy;
    logic [7:0] rx_count;

    logic       pre_en = 1'b0;
    logic [7:0] pre_addr = 8'd0;
    logic [7:0] pre_data = 8'd0;
    logic [7:0] ram [256];
    int         wr_pulses = 0;

    int         n_tests = 0;
    int         n_fail = 0;

    logic [7:0] exp_mem [256];
    int         model_ptr = 0;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_regport #(.SLAVE_ADDR(7'h48), .ADDR_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .ram_add  (ram_add),
        .ram_din  (ram_din),
        .ram_w    (ram_w),
        .ram_dout (ram_dout),
        .busy     (busy),
        .rx_count (rx_count)
    );

    always @(posedge clk) begin
        if (pre_en) ram[pre_addr] <= pre_data;
        else if (ram_w) begin
            ram[ram_add] <= ram_din;
            wr_pulses    <= wr_pulses + 1;
        end
        ram_dout <= ram[ram_add];
    end

    // ---------------- reference model ----------------
    function automatic void model_write(input logic [7:0] d);
        exp_mem[model_ptr] = d;
        model_ptr = (model_ptr + 1) % 256;
    endfunction

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
        exp_mem[a] = d;
    endtask

    // ---------------- bus master ----------------
    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1;       wait_q();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b0;       wait_q();
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wait_q();
        scl = 1'b1;       wait_q();
        m_sda_low = 1'b0; wait_q();
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = !b; wait_q();
        scl = 1'b1;     wait_q(); wait_q();
        scl = 1'b0;     wait_q();
    endtask

    task automatic recv_bit(output logic b);
        m_sda_low = 1'b0; wait_q();
        scl = 1'b1;       wait_q();
        b = sda;          wait_q();
        scl = 1'b0;       wait_q();
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(b);
        ack = !b;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(!ack);
    endtask

    task automatic check_mem(input string name);
        int bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== exp_mem[i]) bad++;
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d RAM bytes differ from model, required 0", name, bad);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_tests++; if (sda !== 1'b1)    begin n_fail++; $display("FAIL reset_sda: got %b required 1", sda); end
        n_tests++; if (ram_w !== 1'b0)  begin n_fail++; $display("FAIL reset_ram_w: got %b required 0", ram_w); end
        n_tests++; if (ram_add !== 8'h00) begin n_fail++; $display("FAIL reset_ram_add: got %h required 00", ram_add); end
        n_tests++; if (ram_din !== 8'h00) begin n_fail++; $display("FAIL reset_ram_din: got %h required 00", ram_din); end
        n_tests++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_tests++; if (rx_count !== 8'h00) begin n_fail++; $display("FAIL reset_rx_count: got %h required 00", rx_count); end
    endtask

    task automatic test_write();
        logic [3:0] acks;
        i2c_start();
        send_byte({7'h48, 1'b0}, acks[3]);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_hi: got %b required 1", busy); end
        send_byte(8'h10, acks[2]); model_ptr = 8'h10;
        send_byte(8'hAA, acks[1]); model_write(8'hAA);
        send_byte(8'h55, acks[0]); model_write(8'h55);
        n_tests++; if (acks !== 4'b1111) begin n_fail++; $display("FAIL write_acks: got %b required 1111", acks); end
        n_tests++; if (rx_count !== 8'd2) begin n_fail++; $display("FAIL write_rx_count: got %0d required 2", rx_count); end
        i2c_stop(); wait_q();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_lo: got %b required 0", busy); end
        check_mem("write_mem");
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        int w0;
        w0 = wr_pulses;
        i2c_start();
        send_byte({7'h49, 1'b0}, a0);
        n_tests++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_ack: got %b required 0", a0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_busy: got %b required 0", busy); end
        send_byte(8'($urandom), a1);
        n_tests++; if (a1 !== 1'b0) begin n_fail++; $display("FAIL wrong_addr_data_ack: got %b required 0", a1); end
        i2c_stop(); wait_q();
        n_tests++; if (wr_pulses != w0) begin n_fail++; $display("FAIL wrong_addr_ram_w: got %0d pulses required 0", wr_pulses - w0); end
    endtask

    task automatic test_general_call();
        logic a0;
        i2c_start();
        send_byte(8'h00, a0);
        n_tests++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL general_call_ack: got %b required 0", a0); end
        i2c_stop(); wait_q();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL general_call_busy: got %b required 0", busy); end
    endtask

    task automatic test_repeated_read();
        logic [2:0] acks;
        logic [7:0] d0, d1;
        logic [7:0] e0, e1;
        preload(8'h20, 8'h3C);
        preload(8'h21, 8'hC3);
        i2c_start();
        send_byte({7'h48, 1'b0}, acks[2]);
        send_byte(8'h20, acks[1]); model_ptr = 8'h20;
        i2c_start();
        send_byte({7'h48, 1'b1}, acks[0]);
        e0 = exp_mem[model_ptr]; model_ptr = (model_ptr + 1) % 256;
        recv_byte(1'b1, d0);
        e1 = exp_mem[model_ptr];
        recv_byte(1'b0, d1);
        n_tests++; if (acks !== 3'b111) begin n_fail++; $display("FAIL read_acks: got %b required 111", acks); end
        n_tests++; if (d0 !== e0) begin n_fail++; $display("FAIL read_byte0: got %h required %h", d0, e0); end
        n_tests++; if (d1 !== e1) begin n_fail++; $display("FAIL read_byte1: got %h required %h", d1, e1); end
        wait_q();
        n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL read_release: got %b required 1", sda); end
        i2c_stop(); wait_q();
    endtask

    task automatic test_wrap();
        logic [3:0] acks;
        i2c_start();
        send_byte({7'h48, 1'b0}, acks[3]);
        send_byte(8'hFF, acks[2]); model_ptr = 8'hFF;
        send_byte(8'h11, acks[1]); model_write(8'h11);
        send_byte(8'h22, acks[0]); model_write(8'h22);
        i2c_stop(); wait_q();
        n_tests++; if (acks !== 4'b1111) begin n_fail++; $display("FAIL wrap_acks: got %b required 1111", acks); end
        check_mem("wrap_mem");
    endtask

    task automatic test_abort_start();
        logic [4:0] acks;
        logic [7:0] p, d;
        p = 8'($urandom_range(16, 250));
        d = 8'($urandom);
        i2c_start();
        send_byte({7'h48, 1'b0}, acks[4]);
        send_byte(p, acks[3]);
        for (int i = 0; i < 3; i++) send_bit(1'($urandom));
        i2c_start();
        send_byte({7'h48, 1'b0}, acks[2]);
        send_byte(8'h05, acks[1]); model_ptr = 8'h05;
        send_byte(d, acks[0]);     model_write(d);
        n_tests++; if (rx_count !== 8'd1) begin n_fail++; $display("FAIL abort_rx_count: got %0d required 1", rx_count); end
        i2c_stop(); wait_q();
        n_tests++; if (acks !== 5'b11111) begin n_fail++; $display("FAIL abort_acks: got %b required 11111", acks); end
        check_mem("abort_mem");
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 4; it++) begin
            logic [7:0] p, d, e;
            logic       a, all_ack;
            int         len;
            p = (it == 0) ? 8'hFE : 8'($urandom);
            len = $urandom_range(2, 4);
            all_ack = 1'b1;
            i2c_start();
            send_byte({7'h48, 1'b0}, a); all_ack &= a;
            send_byte(p, a); all_ack &= a; model_ptr = p;
            for (int k = 0; k < len; k++) begin
                d = 8'($urandom);
                send_byte(d, a); all_ack &= a;
                model_write(d);
            end
            n_tests++; if (rx_count !== 8'(len)) begin n_fail++; $display("FAIL b2b_rx_count[%0d]: got %0d required %0d", it, rx_count, len); end
            i2c_start();
            send_byte({7'h48, 1'b0}, a); all_ack &= a;
            send_byte(p, a); all_ack &= a; model_ptr = p;
            i2c_start();
            send_byte({7'h48, 1'b1}, a); all_ack &= a;
            for (int k = 0; k < len; k++) begin
                e = exp_mem[model_ptr];
                recv_byte(k != len - 1, d);
                if (k != len - 1) model_ptr = (model_ptr + 1) % 256;
                n_tests++; if (d !== e) begin n_fail++; $display("FAIL b2b_read[%0d.%0d]: got %h required %h", it, k, d, e); end
            end
            i2c_stop(); wait_q();
            n_tests++; if (all_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_acks[%0d]: got %b required 1", it, all_ack); end
        end
        check_mem("b2b_mem");
    endtask

    task automatic test_reset_mid_ack();
        logic [2:0] acks;
        logic [7:0] p, d;
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : (8'h90 >> i) & 1'b1);
        m_sda_low = 1'b0;
        @(negedge clk);
        n_tests++; if (sda !== 1'b0) begin n_fail++; $display("FAIL midack_driven: got %b required 0", sda); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midack_busy: got %b required 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL midack_release: got %b required 1", sda); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midack_busy_rst: got %b required 0", busy); end
        n_tests++; if (ram_add !== 8'h00) begin n_fail++; $display("FAIL midack_ram_add: got %h required 00", ram_add); end
        n_tests++; if (rx_count !== 8'h00 || ram_w !== 1'b0 || ram_din !== 8'h00)
            begin n_fail++; $display("FAIL midack_outputs: got rx=%h w=%b din=%h required 00 0 00", rx_count, ram_w, ram_din); end
        wait_q(); wait_q();
        n_tests++; if (sda !== 1'b1) begin n_fail++; $display("FAIL midack_ignore: got %b required 1", sda); end
        i2c_stop(); wait_q();
        p = 8'($urandom); d = 8'($urandom);
        i2c_start();
        send_byte({7'h48, 1'b0}, acks[2]);
        send_byte(p, acks[1]); model_ptr = p;
        send_byte(d, acks[0]); model_write(d);
        i2c_stop(); wait_q();
        n_tests++; if (acks !== 3'b111) begin n_fail++; $display("FAIL midack_after_acks: got %b required 111", acks); end
        check_mem("midack_mem");
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        test_reset();
        test_write();
        test_wrong_addr();
        test_general_call();
        test_repeated_read();
        test_wrap();
        test_abort_start();
        test_back_to_back();
        test_reset_mid_ack();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
